// File: rtl/serial_subtractor_8bit_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_8bit_pkg
//   Shared ALU constants and types for the bit-serial subtractor.
//   - ALU_WIDTH / ALU_OUT_WIDTH : operand width and result bus width, kept
//     identical to the values used by the carry-lookahead adder.
//   - sub_state_e               : serial subtractor FSM encoding.
//   - fs_borrow / fs_diff       : single-bit full-subtractor equations.
// ---------------------------------------------------------------------------
package serial_subtractor_8bit_pkg;

   localparam int ALU_WIDTH     = 8;
   localparam int ALU_OUT_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sub_state_e;

   // Difference bit of a - b - bin.
   function automatic logic fs_diff(input logic a, input logic b, input logic bin);
      return a ^ b ^ bin;
   endfunction

   // Borrow out of a - b - bin: borrow when a < b, or when a == b and a
   // borrow is already pending.
   function automatic logic fs_borrow(input logic a, input logic b, input logic bin);
      return (~a & b) | (~(a ^ b) & bin);
   endfunction

endpackage

// File: rtl/serial_subtractor_8bit_fs.sv
// ---------------------------------------------------------------------------
// full_subtractor_1bit
//   Purely combinational one-bit full subtractor, reused on every serial step.
//   Ports:
//     a    in  1  minuend bit
//     b    in  1  subtrahend bit
//     bin  in  1  borrow-in
//     d    out 1  difference bit
//     bout out 1  borrow-out
// ---------------------------------------------------------------------------
module full_subtractor_1bit
   import serial_subtractor_8bit_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = fs_diff(a, b, bin);
   assign bout = fs_borrow(a, b, bin);

endmodule

// File: rtl/serial_subtractor_8bit.sv
// ---------------------------------------------------------------------------
// serial_subtractor_8bit
//   Bit-serial subtractor computing (a - b - bin) one bit per clock, LSB
//   first. Result is presented zero-extended on OUT_WIDTH bits and gated by
//   enable_sub, matching the ALU result mux format.
//   Ports:
//     clk        in  1          rising-edge clock
//     rst_n      in  1          asynchronous active-low reset
//     a          in  WIDTH      minuend, sampled on an accepted start
//     b          in  WIDTH      subtrahend, sampled on an accepted start
//     bin        in  1          borrow-in, sampled on an accepted start
//     enable_sub in  1          qualifies start, aborts RUN, gates outputs
//     start      in  1          level-sampled request
//     busy       out 1          high in RUN and DONE
//     done       out 1          one-cycle completion pulse
//     DIFF       out OUT_WIDTH  {zeros, diff}, 0 while enable_sub is low
//     BOUT       out 1          borrow-out, 0 while enable_sub is low
// ---------------------------------------------------------------------------
module serial_subtractor_8bit
   import serial_subtractor_8bit_pkg::*;
#(
   parameter int WIDTH     = ALU_WIDTH,
   parameter int OUT_WIDTH = ALU_OUT_WIDTH
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 bin,
   input  logic                 enable_sub,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [OUT_WIDTH-1:0] DIFF,
   output logic                 BOUT
);

   localparam int                CNT_W     = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(WIDTH - 1);
   localparam int                PAD_W     = OUT_WIDTH - WIDTH;

   sub_state_e       state_r;
   sub_state_e       state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] diff_sh_r;
   logic [WIDTH-1:0] result_r;
   logic             borrow_r;
   logic             bout_r;

   logic             d_s;
   logic             borrow_step_s;
   logic             accept_s;
   logic             step_s;
   logic             last_s;
   logic [WIDTH-1:0] diff_shifted_s;

   full_subtractor_1bit u_fs (
      .a    (a_sh_r[0]),
      .b    (b_sh_r[0]),
      .bin  (borrow_r),
      .d    (d_s),
      .bout (borrow_step_s)
   );

   // New difference bit enters at the MSB so the first (LSB) bit ends up at
   // bit 0 after WIDTH shifts.
   assign diff_shifted_s = {d_s, diff_sh_r[WIDTH-1:1]};

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and datapath control decode.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      step_s      = 1'b0;
      last_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start && enable_sub) begin
               state_nxt_s = ST_RUN;
               accept_s    = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Dropping enable_sub abandons the operation; the abort wins
            // even on the final step so no done and no result update occur.
            if (!enable_sub) begin
               state_nxt_s = ST_IDLE;
            end else begin
               step_s = 1'b1;
               if (cnt_r == LAST_STEP) begin
                  last_s      = 1'b1;
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Operand shift registers, running borrow and step counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_r    <= {WIDTH{1'b0}};
         b_sh_r    <= {WIDTH{1'b0}};
         diff_sh_r <= {WIDTH{1'b0}};
         borrow_r  <= 1'b0;
         cnt_r     <= {CNT_W{1'b0}};
      end else if (accept_s) begin
         a_sh_r    <= a;
         b_sh_r    <= b;
         diff_sh_r <= {WIDTH{1'b0}};
         borrow_r  <= bin;
         cnt_r     <= {CNT_W{1'b0}};
      end else if (step_s) begin
         a_sh_r    <= {1'b0, a_sh_r[WIDTH-1:1]};
         b_sh_r    <= {1'b0, b_sh_r[WIDTH-1:1]};
         diff_sh_r <= diff_shifted_s;
         borrow_r  <= borrow_step_s;
         cnt_r     <= last_s ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1));
      end
   end

   // Completed result: holds until the next completion or reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_r <= {WIDTH{1'b0}};
         bout_r   <= 1'b0;
      end else if (last_s) begin
         result_r <= diff_shifted_s;
         bout_r   <= borrow_step_s;
      end
   end

   // Status is a direct decode of the state register; result outputs are
   // gated by enable_sub, the only combinational input-to-output path.
   assign busy = (state_r != ST_IDLE);
   assign done = (state_r == ST_DONE);
   assign DIFF = enable_sub ? {{PAD_W{1'b0}}, result_r} : {OUT_WIDTH{1'b0}};
   assign BOUT = enable_sub & bout_r;

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
module tb_serial_subtractor_8bit;

   logic        clk;
   logic        rst_n;
   logic [7:0]  tb_a;
   logic [7:0]  tb_b;
   logic        tb_bin;
   logic        enable_sub;
   logic        start;
   logic        busy;
   logic        done;
   logic [15:0] DIFF;
   logic        BOUT;

   int total = 0;
   int bad   = 0;
   int done_count = 0;

   // Expected {bout, diff} per accepted operation.
   logic [8:0] exp_q[$];

   serial_subtractor_8bit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a          (tb_a),
      .b          (tb_b),
      .bin        (tb_bin),
      .enable_sub (enable_sub),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .DIFF       (DIFF),
      .BOUT       (BOUT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [8:0] sub_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic bin);
      logic [8:0] t;
      t = {1'b0, a} - {1'b0, b} - {8'b0, bin};
      return t;
   endfunction

   // Scoreboard: every done pulse retires the oldest expected result.
   always @(negedge clk) begin
      logic [8:0]  e;
      logic [15:0] e_diff;
      logic        e_bout;
      if (rst_n && done) begin
         done_count++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL done_unexpected: done pulse with empty scoreboard, DIFF=%h", DIFF);
         end else begin
            e      = exp_q.pop_front();
            e_diff = enable_sub ? {8'h00, e[7:0]} : 16'h0000;
            e_bout = enable_sub & e[8];
            if (DIFF !== e_diff) begin
               bad++;
               $display("FAIL sb_diff: got %h expected %h", DIFF, e_diff);
            end
            total++;
            if (BOUT !== e_bout) begin
               bad++;
               $display("FAIL sb_bout: got %b expected %b", BOUT, e_bout);
            end
         end
      end
   end

   // Drive one start cycle; returns at the negedge just after the accept edge.
   task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bin);
      @(negedge clk);
      tb_a       = a;
      tb_b       = b;
      tb_bin     = bin;
      enable_sub = 1'b1;
      start      = 1'b1;
      exp_q.push_back(sub_model(a, b, bin));
      @(negedge clk);
      start = 1'b0;
   endtask

   // Observe 30 negedges: index of first done sample (-1 if none) and busy count.
   task automatic wait_done(output int lat, output int busy_cycles);
      lat = -1;
      busy_cycles = 0;
      for (int i = 0; i < 30; i++) begin
         if (busy === 1'b1) busy_cycles++;
         if (done === 1'b1 && lat < 0) lat = i;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable_sub = 1'b1; start = 1'b0;
      tb_a = 8'h00; tb_b = 8'h00; tb_bin = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
      total++; if (DIFF !== 16'h0000) begin bad++; $display("FAIL reset_diff: got %h expected 0000", DIFF); end
      total++; if (BOUT !== 1'b0) begin bad++; $display("FAIL reset_bout: got %b expected 0", BOUT); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int lat, bc, d0;
      start_op(8'h3C, 8'h15, 1'b0);
      d0 = done_count;
      wait_done(lat, bc);
      total++; if (lat !== 8) begin bad++; $display("FAIL basic_latency: got %0d expected 8", lat); end
      total++; if (bc !== 9) begin bad++; $display("FAIL basic_busy_cycles: got %0d expected 9", bc); end
      total++; if (done_count - d0 !== 1) begin bad++; $display("FAIL basic_done_count: got %0d expected 1", done_count - d0); end
      total++; if (DIFF !== 16'h0027) begin bad++; $display("FAIL basic_hold: got %h expected 0027", DIFF); end
   endtask

   task automatic test_borrow();
      int lat, bc;
      start_op(8'h10, 8'h20, 1'b0);
      wait_done(lat, bc);
      total++; if (lat !== 8) begin bad++; $display("FAIL borrow_latency: got %0d expected 8", lat); end
      total++; if (BOUT !== 1'b1) begin bad++; $display("FAIL borrow_hold: got %b expected 1", BOUT); end
   endtask

   task automatic test_boundary();
      logic [16:0] vec [4];
      int lat, bc;
      vec[0] = {8'h00, 8'h00, 1'b1};
      vec[1] = {8'hFF, 8'hFF, 1'b0};
      vec[2] = {8'hA5, 8'h5A, 1'b1};
      vec[3] = {8'h01, 8'h02, 1'b1};
      for (int i = 0; i < 4; i++) begin
         start_op(vec[i][16:9], vec[i][8:1], vec[i][0]);
         wait_done(lat, bc);
         total++; if (lat !== 8) begin bad++; $display("FAIL boundary_latency[%0d]: got %0d expected 8", i, lat); end
      end
   endtask

   task automatic test_start_while_busy();
      int lat, bc, d0;
      start_op(8'h50, 8'h01, 1'b0);
      d0 = done_count;
      repeat (2) @(negedge clk);
      tb_a = 8'h00; tb_b = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bc);
      total++; if (lat !== 5) begin bad++; $display("FAIL busy_start_latency: got %0d expected 5", lat); end
      total++; if (done_count - d0 !== 1) begin bad++; $display("FAIL busy_start_dones: got %0d expected 1", done_count - d0); end
      total++; if (DIFF !== 16'h004F) begin bad++; $display("FAIL busy_start_diff: got %h expected 004F", DIFF); end
   endtask

   task automatic test_abort();
      int lat, bc, d0;
      start_op(8'h3C, 8'h15, 1'b0);
      wait_done(lat, bc);
      start_op(8'h10, 8'h20, 1'b0);
      repeat (4) @(negedge clk);
      enable_sub = 1'b0;
      #1;
      total++; if (DIFF !== 16'h0000) begin bad++; $display("FAIL abort_gate_diff: got %h expected 0000", DIFF); end
      total++; if (BOUT !== 1'b0) begin bad++; $display("FAIL abort_gate_bout: got %b expected 0", BOUT); end
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle: busy got %b expected 0", busy); end
      d0 = done_count;
      wait_done(lat, bc);
      total++; if (lat !== -1 || done_count !== d0) begin bad++; $display("FAIL abort_no_done: lat got %0d expected -1", lat); end
      void'(exp_q.pop_back());
      enable_sub = 1'b1;
      #1;
      total++; if (DIFF !== 16'h0027) begin bad++; $display("FAIL abort_kept_diff: got %h expected 0027", DIFF); end
      total++; if (BOUT !== 1'b0) begin bad++; $display("FAIL abort_kept_bout: got %b expected 0", BOUT); end
   endtask

   task automatic test_async_reset();
      int lat, bc;
      start_op(8'h10, 8'h20, 1'b0);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_busy: got %b expected 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL areset_done: got %b expected 0", done); end
      total++; if (DIFF !== 16'h0000) begin bad++; $display("FAIL areset_diff: got %h expected 0000", DIFF); end
      total++; if (BOUT !== 1'b0) begin bad++; $display("FAIL areset_bout: got %b expected 0", BOUT); end
      void'(exp_q.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      start_op(8'h80, 8'h01, 1'b0);
      wait_done(lat, bc);
      total++; if (lat !== 8) begin bad++; $display("FAIL areset_restart_latency: got %0d expected 8", lat); end
      total++; if (DIFF !== 16'h007F) begin bad++; $display("FAIL areset_restart_diff: got %h expected 007F", DIFF); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_borrow();
      test_boundary();
      test_start_while_busy();
      test_abort();
      test_async_reset();
      total++;
      if (exp_q.size() !== 0) begin
         bad++;
         $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_subtractor_8bit.md
# serial_subtractor_8bit

Bit-serial 8-bit subtractor computing a − b − bin one bit per clock, LSB first, with a start/busy/done handshake. It is the subtraction counterpart of the 8-bit carry-lookahead adder in the ALU datapath. It trades area for latency and presents its result in the same 16-bit zero-extended, enable-gated format the ALU result mux already consumes.

## Interface
Parameters:
- WIDTH, 8: operand width and number of serial steps.
- OUT_WIDTH, 16: result bus width; the upper OUT_WIDTH−WIDTH bits are always zero.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- a  in  8  minuend; sampled only on an accepted start.
- b  in  8  subtrahend; sampled only on an accepted start.
- bin  in  1  borrow-in; sampled only on an accepted start.
- enable_sub  in  1  operation select: qualifies start, aborts when low, and gates the outputs.
- start  in  1  request; level-sampled.
- busy  out  1  high in the RUN and DONE states.
- done  out  1  one-cycle completion pulse.
- DIFF  out  16  result {8'b0, diff}; reads 0 while enable_sub is low.
- BOUT  out  1  borrow-out; reads 0 while enable_sub is low.

## Operation
- States:
  - IDLE: idle.
  - RUN: serial steps in progress.
  - DONE: one-cycle completion state.
- IDLE → RUN when start && enable_sub at a clock edge.
  - Capture a, b into shift registers.
  - Load the borrow register with bin.
  - Clear the step counter to 0.
- Each edge in RUN performs one step:
  - d = a_sh[0] ^ b_sh[0] ^ borrow.
  - borrow ← (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow).
  - Shift d into the MSB of diff_sh; shift diff_sh, a_sh and b_sh right by one.
  - Increment the counter.
- On the step with counter == WIDTH−1:
  - Load result_reg ← diff_sh after the final shift.
  - Load bout_reg ← final borrow.
  - Go to DONE.
- DONE → IDLE unconditionally after one cycle. done = (state == DONE).
- Arithmetic: diff = (a − b − bin) mod 256. BOUT = 1 iff a < b + bin (unsigned).
- Output gating is combinational:
  - DIFF = enable_sub ? {8'b0, result_reg} : 16'b0.
  - BOUT = enable_sub ? bout_reg : 0.
- result_reg and bout_reg hold the last completed result until the next completion or reset.
- Boundary rules:
  - start while busy (RUN or DONE) is ignored; operands are not re-sampled.
  - start with enable_sub low is ignored.
  - enable_sub low during RUN aborts to IDLE at the next edge: no done pulse, result_reg and bout_reg unchanged.
  - enable_sub low during DONE: done still pulses; the gated outputs read 0.
  - rst_n low at any time, including mid-RUN, immediately forces the reset state of every register.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - All shift, result and borrow registers 0.
  - Outputs busy 0, done 0, DIFF 0, BOUT 0.
- Edges are numbered from the accept edge E0:
  - busy is high from E0 until E9.
  - Steps occur at E1..E8; result_reg and bout_reg load at E8.
  - done is high for exactly the cycle between E8 and E9.
- Latency: DIFF/BOUT show the new value 8 cycles after the accept edge, in the same cycle as done.
- Earliest next accept is at E10. Throughput is one operation per 10 cycles.
- No combinational path from a, b or bin to any output. enable_sub → DIFF/BOUT is the only combinational path.

## Structure
- Shared ALU package/header:
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - WIDTH and OUT_WIDTH constants, shared with the adder.
- Sub-module full_subtractor_1bit: inputs (a, b, bin), outputs (d, bout). One instance is reused every step.
- Top level holds:
  - the FSM,
  - a 3-bit step counter (wraps at WIDTH−1 → 0 on the transition to DONE),
  - the shift registers and the gated output logic.

## Test plan
- a=8'h3C, b=8'h15, bin=0, start one cycle → done in the cycle after E8; DIFF=16'h0027, BOUT=0; busy high exactly 9 cycles.
- a=8'h10, b=8'h20, bin=0 → DIFF=16'h00F0, BOUT=1.
- Boundary operands:
  - a=8'h00, b=8'h00, bin=1 → DIFF=16'h00FF, BOUT=1.
  - a=8'hFF, b=8'hFF, bin=0 → DIFF=16'h0000, BOUT=0.
- Start with a=8'h50, b=8'h01, bin=0; pulse start at E3 with a=8'h00, b=8'hFF → second start ignored; DIFF=16'h004F, BOUT=0; exactly one done.
- Complete 8'h3C−8'h15, then start 8'h10−8'h20 and drop enable_sub after E4 → DIFF/BOUT read 0 while low; FSM in IDLE by the next edge; no done. Re-assert enable_sub → DIFF=16'h0027, BOUT=0.
- Assert rst_n low asynchronously after E5 → busy, done, DIFF, BOUT all 0 before the next edge. After release, 8'h80−8'h01 → DIFF=16'h007F, BOUT=0.
